dmem_tl_slave: RTL
==================

// Module: dmem_tl_slave
// PURPOSE
//   Data-memory slave on the core's channel-2 bus (TileLink-UL-style A/D channels).
//   Accepts Get (3'b100) and PutFullData (3'b000) requests from the core's A channel
//   into a 2-entry request FIFO. It performs word accesses on an internal RAM and
//   returns AccessAckData (3'b001) or AccessAck (3'b000) on the D channel.
//   Sits directly downstream of the core top and produces d_data_i_2/d_opcode_i_2/d2_ready_i.
// PARAMETERS
//   DEPTH_WORDS  1024   RAM depth in 32-bit words; only ADDR_W-2 word-index bits are used
//   ADDR_W       12     A-channel address width; [ADDR_W-1:ADDR_W-2] = region, rest = word index
//   REGION       2'b01  region code this slave decodes (data memory)
// PORTS
//   clk          in   1   clock, all state updates on rising edge
//   reset        in   1   synchronous, active-high reset
//   a_valid_i    in   1   request valid (driven by core a_ready_o_2)
//   a_opcode_i   in   3   3'b100 Get, 3'b000 PutFullData; other codes are illegal
//   a_address_i  in   12  {region[1:0], word_index[9:0]}
//   a_data_i     in   32  write data, PutFullData only
//   a_accept_o   out  1   slave can take a request this cycle
//   d_valid_o    out  1   response valid (to core d2_ready_i)
//   d_opcode_o   out  3   3'b001 AccessAckData (Get), 3'b000 AccessAck (Put)
//   d_data_o     out  32  read data; 0 for Put or error
//   d_error_o    out  1   request was illegal (bad opcode or region mismatch)
//   d_accept_i   in   1   consumer takes response this cycle
// BEHAVIOUR
//   Reset (reset=1 at an edge): FIFO count=0, response register EMPTY.
//     Outputs: d_valid_o=0, d_opcode_o=0, d_data_o=0, d_error_o=0, a_accept_o=1 in the next cycle.
//     Reset does not clear RAM contents. Reset mid-operation drops all queued requests and the pending response.
//   Request FIFO: 2 entries of {opcode, address, data}; a_accept_o = (count<2), driven from registered state only.
//     Push when a_valid_i && a_accept_o. When full, no pass-through: a_valid_i is ignored.
//   Issue: head pops when count>0 && (resp EMPTY || d_accept_i). Push and pop may happen in the same cycle (count unchanged).
//     Legal Put: RAM[word_index] <= data at the issue edge.
//     Legal Get: RAM read registered at the issue edge into d_data_o.
//     Legal = opcode in {000,100} && region==REGION. Illegal: no RAM access, d_error_o=1, d_data_o=0,
//       d_opcode_o=3'b001 for Get, 3'b000 otherwise.
//   Response FSM (EMPTY/FULL): EMPTY->FULL on issue.
//     FULL->EMPTY on d_accept_i with no issue. FULL->FULL on d_accept_i with issue (back-to-back).
//     FULL holds while d_accept_i=0; d_* outputs are stable while d_valid_o && !d_accept_i.
//   Latency: request accepted at edge N (FIFO and response empty) -> issue at edge N+1 -> d_valid_o=1 in cycle N+1..N+2.
//     Response is visible after edge N+1. Sustained throughput is 1 request/cycle when d_accept_i=1.
//   Ordering: strict FIFO; a Get after a Put to the same word returns the new data. Word index wraps modulo DEPTH_WORDS.
// TESTING
//   reset=1 for 2 cycles with a_valid_i=1 -> d_valid_o=0, count stays 0, then a_accept_o=1 after release.
//   Put 0xDEADBEEF @12'h404 then Get @12'h404, d_accept_i=1 -> AccessAck (000), then AccessAckData (001) with data=0xDEADBEEF, error=0.
//   d_accept_i=0, issue 3 Gets -> response holds, FIFO fills, a_accept_o=0; raise d_accept_i -> three in-order responses, one per cycle.
//   Get @12'h804 (region 2'b10) -> d_error_o=1, d_data_o=0, opcode 001; RAM unchanged.
//   Opcode 3'b011 @12'h400 -> d_error_o=1, opcode 000, no write.
//   Assert reset with 2 queued requests and a pending response -> all dropped; a previously written word still reads back its old value.

Source files
------------

// File: rtl/dmem_tl_slave.sv
// Data-memory slave: 2-entry request FIFO feeding a word RAM, single-register D-channel response.
// Latency: request accepted at edge N issues at edge N+1; response visible after N+1.
// Backpressure: a_accept_o drops when the FIFO holds 2 entries; the response holds while d_accept_i=0.
module dmem_tl_slave #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          ADDR_W      = 12,
  parameter logic [1:0]  REGION      = 2'b01
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid_i,
  input  logic [2:0]        a_opcode_i,
  input  logic [ADDR_W-1:0] a_address_i,
  input  logic [31:0]       a_data_i,
  output logic              a_accept_o,
  output logic              d_valid_o,
  output logic [2:0]        d_opcode_o,
  output logic [31:0]       d_data_o,
  output logic              d_error_o,
  input  logic              d_accept_i
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  localparam logic [2:0] OP_GET      = 3'b100;
  localparam logic [2:0] OP_PUT      = 3'b000;
  localparam logic [2:0] OP_ACK      = 3'b000;
  localparam logic [2:0] OP_ACK_DATA = 3'b001;

  typedef struct packed {
    logic [2:0]        opcode;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } req_t;

  typedef enum logic {RESP_EMPTY, RESP_FULL} resp_state_e;

  // Request FIFO state
  logic [1:0] count_q, count_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  req_t       fifo_q [2];
  req_t       fifo_d [2];

  // Response register state
  resp_state_e state_q, state_d;
  logic [2:0]  d_opcode_q, d_opcode_d;
  logic [31:0] d_data_q, d_data_d;
  logic        d_error_q, d_error_d;

  logic [31:0] ram [DEPTH_WORDS];

  logic             push;
  logic             issue;
  req_t             head;
  logic [1:0]       head_region;
  logic [IDX_W-1:0] head_idx;
  logic             head_is_get;
  logic             head_is_put;
  logic             head_legal;
  logic             ram_we;

  // Accept depends only on registered occupancy, so there is no comb path from a_valid_i.
  assign a_accept_o  = (count_q < 2'd2);
  assign push        = a_valid_i && a_accept_o;
  assign issue       = (count_q != 2'd0) && ((state_q == RESP_EMPTY) || d_accept_i);

  assign head        = fifo_q[rd_ptr_q];
  assign head_region = head.addr[ADDR_W-1 -: 2];
  assign head_idx    = head.addr[IDX_W-1:0];
  assign head_is_get = (head.opcode == OP_GET);
  assign head_is_put = (head.opcode == OP_PUT);
  assign head_legal  = (head_is_get || head_is_put) && (head_region == REGION);
  // Reset must not let a queued Put reach the RAM.
  assign ram_we      = issue && head_is_put && head_legal && !reset;

  assign d_valid_o   = (state_q == RESP_FULL);
  assign d_opcode_o  = d_opcode_q;
  assign d_data_o    = d_data_q;
  assign d_error_o   = d_error_q;

  // FIFO next state: write at wr_ptr on push, advance rd_ptr on issue.
  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + {1'b0, push} - {1'b0, issue};
    if (push) begin
      fifo_d[wr_ptr_q] = '{opcode: a_opcode_i, addr: a_address_i, data: a_data_i};
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (issue) begin
      rd_ptr_d = ~rd_ptr_q;
    end
  end

  // FIFO occupancy and pointers; reset empties the queue.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // FIFO payload storage; entries are only meaningful while counted.
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

  // RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[head_idx] <= head.data;
    end
  end

  // Response FSM: load on issue, retire on accept, otherwise hold outputs stable.
  always_comb begin
    state_d    = state_q;
    d_opcode_d = d_opcode_q;
    d_data_d   = d_data_q;
    d_error_d  = d_error_q;
    if (issue) begin
      state_d    = RESP_FULL;
      d_opcode_d = head_is_get ? OP_ACK_DATA : OP_ACK;
      d_error_d  = !head_legal;
      d_data_d   = (head_legal && head_is_get) ? ram[head_idx] : 32'd0;
    end else if ((state_q == RESP_FULL) && d_accept_i) begin
      state_d = RESP_EMPTY;
    end
  end

  // Response register; reset drops any pending response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RESP_EMPTY;
      d_opcode_q <= 3'd0;
      d_data_q   <= 32'd0;
      d_error_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      d_opcode_q <= d_opcode_d;
      d_data_q   <= d_data_d;
      d_error_q  <= d_error_d;
    end
  end

endmodule
